// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment capture block: digit count, field widths
// and the active-high abcdefg hex glyph table (a = MSB).
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int NIB_W      = 4;
    localparam int CNT_W      = 8;

    // Entry i is the glyph for hex digit i; listed F down to 0 so index 0 is the LSB slot.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

endpackage

// File: rtl/sevenseg_capture_if.sv
// Bundle of the scanned-display inputs and the recovered-frame outputs.
// master drives the display lines; slave is the capture block.
interface sevenseg_capture_if;
    import sevenseg_pkg::*;

    logic [SEG_W-1:0]            seg_in;
    logic                        dp_in;
    logic [NUM_DIGITS-1:0]       digit_en;
    logic [NUM_DIGITS*NIB_W-1:0] digit_val;
    logic [NUM_DIGITS-1:0]       dp_val;
    logic [NUM_DIGITS-1:0]       invalid;
    logic                        frame_valid;

    modport master (
        output seg_in,
        output dp_in,
        output digit_en,
        input  digit_val,
        input  dp_val,
        input  invalid,
        input  frame_valid
    );

    modport slave (
        input  seg_in,
        input  dp_in,
        input  digit_en,
        output digit_val,
        output dp_val,
        output invalid,
        output frame_valid
    );

endinterface

// File: rtl/seg_to_hex.sv
// Combinational glyph decoder: maps an abcdefg pattern to its hex nibble and
// flags whether the pattern is a known glyph at all.
module seg_to_hex
    import sevenseg_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [NIB_W-1:0] nibble,
    output logic             match
);

    always_comb begin
        nibble = '0;
        match  = 1'b0;
        // Table entries are unique, so at most one iteration hits.
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                nibble = NIB_W'(i);
                match  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Recovers hex digits from a multiplexed 4-digit seven-segment drive: synchronizes the
// lines, waits for a stable dwell, decodes it into a shadow slot and publishes full frames.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sevenseg_capture_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // Saturating increment of the stability counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    logic [SEG_W-1:0]      seg_p0, seg_p1, seg_p2;
    logic                  dp_p0, dp_p1, dp_p2;
    logic [NUM_DIGITS-1:0] en_p0, en_p1, en_p2;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  change_p1;
    logic                  vld_p2;

    logic [NIB_W-1:0]      dec_nibble;
    logic                  dec_match;

    logic [NUM_DIGITS-1:0][NIB_W-1:0] shadow_nib;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] shadow_inv;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_next;
    logic                  frame_done;

    logic [NUM_DIGITS*NIB_W-1:0] digit_val_q;
    logic [NUM_DIGITS-1:0]       dp_val_q;
    logic [NUM_DIGITS-1:0]       invalid_q;
    logic                        frame_valid_q;

    // Stage p0/p1: two-flop synchronizer; p2 holds the previous synchronized sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0 <= '0;
            dp_p0  <= 1'b0;
            en_p0  <= '0;
            seg_p1 <= '0;
            dp_p1  <= 1'b0;
            en_p1  <= '0;
            seg_p2 <= '0;
            dp_p2  <= 1'b0;
            en_p2  <= '0;
            cnt    <= '0;
        end else begin
            seg_p0 <= bus.seg_in;
            dp_p0  <= bus.dp_in;
            en_p0  <= bus.digit_en;
            seg_p1 <= seg_p0;
            dp_p1  <= dp_p0;
            en_p1  <= en_p0;
            seg_p2 <= seg_p1;
            dp_p2  <= dp_p1;
            en_p2  <= en_p1;
            cnt    <= cnt_next;
        end
    end

    assign change_p1 = {en_p1, seg_p1, dp_p1} != {en_p2, seg_p2, dp_p2};
    assign cnt_next  = change_p1 ? '0 : sat_inc(cnt);

    // Fire only on the transition into saturation so a long dwell captures once;
    // blanked or ghosted selects never qualify.
    assign vld_p2 = (cnt_next == CNT_MAX) && (cnt != CNT_MAX) && $onehot(en_p1);

    seg_to_hex u_seg_to_hex (
        .pattern (seg_p1),
        .nibble  (dec_nibble),
        .match   (dec_match)
    );

    assign frame_done = (seen == '1);

    always_comb begin
        seen_next = frame_done ? '0 : seen;
        if (vld_p2) begin
            seen_next = seen_next | en_p1;
        end
    end

    // Stage p2 -> shadow: a recapture of a seen slot just overwrites its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_nib <= '0;
            shadow_dp  <= '0;
            shadow_inv <= '0;
            seen       <= '0;
        end else begin
            seen <= seen_next;
            if (vld_p2) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (en_p1[i]) begin
                        shadow_nib[i] <= dec_match ? dec_nibble : '0;
                        shadow_dp[i]  <= dp_p1;
                        shadow_inv[i] <= ~dec_match;
                    end
                end
            end
        end
    end

    // Shadow -> outputs: published on the edge after the seen mask fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val_q   <= '0;
            dp_val_q      <= '0;
            invalid_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= frame_done;
            if (frame_done) begin
                digit_val_q <= shadow_nib;
                dp_val_q    <= shadow_dp;
                invalid_q   <= shadow_inv;
            end
        end
    end

    assign bus.digit_val   = digit_val_q;
    assign bus.dp_val      = dp_val_q;
    assign bus.invalid     = invalid_q;
    assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: scan sequences push expected frames into a
// queue, and a monitor compares each frame_valid pulse against the queue head.
module tb_sevenseg_capture;

    localparam int S = 4;

    localparam logic [6:0] G_0   = 7'b1111110;
    localparam logic [6:0] G_1   = 7'b0110000;
    localparam logic [6:0] G_2   = 7'b1101101;
    localparam logic [6:0] G_3   = 7'b1111001;
    localparam logic [6:0] G_4   = 7'b0110011;
    localparam logic [6:0] G_5   = 7'b1011011;
    localparam logic [6:0] G_6   = 7'b1011111;
    localparam logic [6:0] G_7   = 7'b1110000;
    localparam logic [6:0] G_8   = 7'b1111111;
    localparam logic [6:0] G_9   = 7'b1111011;
    localparam logic [6:0] G_A   = 7'b1110111;
    localparam logic [6:0] G_B   = 7'b0011111;
    localparam logic [6:0] G_C   = 7'b1001110;
    localparam logic [6:0] G_D   = 7'b0111101;
    localparam logic [6:0] G_E   = 7'b1001111;
    localparam logic [6:0] G_F   = 7'b1000111;
    localparam logic [6:0] G_BAD = 7'b1010101;

    typedef struct {
        logic [15:0] dv;
        logic [3:0]  dp;
        logic [3:0]  inv;
    } frame_t;

    logic   clk;
    logic   rst_n;
    frame_t exp_q[$];
    int     checks;
    int     errors;
    int     frames_seen;
    logic   prev_fv;

    sevenseg_capture_if bus();

    sevenseg_capture #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic dwell(input logic [3:0] en, input logic [6:0] seg, input logic dp, input int n);
        bus.digit_en = en;
        bus.seg_in   = seg;
        bus.dp_in    = dp;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        dwell(4'b0000, 7'b0000000, 1'b0, n);
    endtask

    task automatic expect_frame(input logic [15:0] dv, input logic [3:0] dp, input logic [3:0] inv);
        frame_t f;
        f.dv  = dv;
        f.dp  = dp;
        f.inv = inv;
        exp_q.push_back(f);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_digit_val"}, 32'(bus.digit_val), 32'h0);
        check({tag, "_dp_val"}, 32'(bus.dp_val), 32'h0);
        check({tag, "_invalid"}, 32'(bus.invalid), 32'h0);
        check({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'h0);
    endtask

    // Monitor: every frame_valid pulse must match the oldest pending expectation.
    initial begin
        frame_t e;
        prev_fv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.frame_valid === 1'b1) begin
                frames_seen++;
                check("fv_single_cycle", 32'(prev_fv), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got digit_val=%h dp_val=%b invalid=%b, required no frame",
                             bus.digit_val, bus.dp_val, bus.invalid);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_digit_val", 32'(bus.digit_val), 32'(e.dv));
                    check("frame_dp_val", 32'(bus.dp_val), 32'(e.dp));
                    check("frame_invalid", 32'(bus.invalid), 32'(e.inv));
                end
            end
            prev_fv = bus.frame_valid;
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        frames_seen = 0;
        rst_n        = 1'b0;
        bus.digit_en = 4'b0000;
        bus.seg_in   = 7'b0000000;
        bus.dp_in    = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        blank(4);

        // Basic scan 1,2,3,4 with dp on digit 2.
        dwell(4'b0001, G_1, 1'b0, 10);
        dwell(4'b0010, G_2, 1'b0, 10);
        dwell(4'b0100, G_3, 1'b1, 10);
        expect_frame(16'h4321, 4'b0100, 4'b0000);
        dwell(4'b1000, G_4, 1'b0, 10);
        blank(8);

        // Digit 1 dwell too short the first time; frame waits for its longer dwell.
        dwell(4'b0001, G_5, 1'b0, 10);
        dwell(4'b0010, G_6, 1'b0, S - 1);
        dwell(4'b0100, G_7, 1'b0, 10);
        dwell(4'b1000, G_8, 1'b0, 10);
        blank(8);
        expect_frame(16'h8765, 4'b0000, 4'b0000);
        dwell(4'b0010, G_6, 1'b0, S + 2);
        blank(8);

        // Ghosted select must not capture; slots 0/1 come only from the clean dwells at the end.
        dwell(4'b0011, G_A, 1'b0, 20);
        dwell(4'b0100, G_C, 1'b0, 10);
        dwell(4'b1000, G_D, 1'b0, 10);
        dwell(4'b0001, G_A, 1'b0, 10);
        expect_frame(16'hDCBA, 4'b0000, 4'b0000);
        dwell(4'b0010, G_B, 1'b0, 10);
        blank(8);

        // Unknown glyph on digit 0, then a frame that repairs it.
        dwell(4'b0001, G_BAD, 1'b0, 10);
        dwell(4'b0010, G_E, 1'b0, 10);
        dwell(4'b0100, G_F, 1'b0, 10);
        expect_frame(16'h0FE0, 4'b0000, 4'b0001);
        dwell(4'b1000, G_0, 1'b0, 10);
        blank(8);
        dwell(4'b0001, G_F, 1'b1, 10);
        dwell(4'b0010, G_9, 1'b0, 10);
        dwell(4'b0100, G_8, 1'b0, 10);
        expect_frame(16'hB89F, 4'b1001, 4'b0000);
        dwell(4'b1000, G_B, 1'b1, 10);
        blank(8);

        // Recapture of digit 0 overwrites it and does not complete the frame early.
        dwell(4'b0001, G_1, 1'b0, 10);
        dwell(4'b0010, G_2, 1'b0, 10);
        dwell(4'b0001, G_7, 1'b0, 10);
        dwell(4'b0100, G_3, 1'b0, 10);
        expect_frame(16'hC327, 4'b0000, 4'b0000);
        dwell(4'b1000, G_C, 1'b0, 10);
        blank(8);

        // Reset after two captures: outputs clear at once and partial captures are lost.
        dwell(4'b0001, G_3, 1'b0, 10);
        dwell(4'b0010, G_3, 1'b1, 10);
        rst_n        = 1'b0;
        bus.digit_en = 4'b0000;
        bus.seg_in   = 7'b0000000;
        bus.dp_in    = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        blank(4);
        dwell(4'b0100, G_9, 1'b0, 10);
        dwell(4'b1000, G_8, 1'b0, 10);
        dwell(4'b0001, G_5, 1'b0, 10);
        expect_frame(16'h8965, 4'b0000, 4'b0000);
        dwell(4'b0010, G_6, 1'b0, 10);
        blank(8);

        // Long steady dwell on digit 2 yields one capture and one frame.
        dwell(4'b0100, G_2, 1'b0, 100);
        dwell(4'b0001, G_5, 1'b0, 10);
        dwell(4'b0010, G_4, 1'b0, 10);
        expect_frame(16'h1245, 4'b0000, 4'b0000);
        dwell(4'b1000, G_1, 1'b0, 10);
        blank(20);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_frames", 32'(exp_q.size()), 32'h0);
        check("frame_count", 32'(frames_seen), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the number of consecutive equal synchronized samples required before a digit is captured; legal range is 2..255.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge, except reset.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 seg_in  input  7  segment lines {a,b,c,d,e,f,g}, a = MSB, active-high (1 = lit).
REQ-005 dp_in  input  1  decimal-point line, active-high.
REQ-006 digit_en  input  4  digit-select lines of a scanned 4-digit display, active-high; bit i selects digit i.
REQ-007 digit_val  output  16  recovered hex nibbles; digit i occupies bits [4i+3:4i].
REQ-008 dp_val  output  4  recovered decimal points, one bit per digit.
REQ-009 invalid  output  4  per-digit flag: the captured pattern was not in the hex table.
REQ-010 frame_valid  output  1  one-cycle pulse when all of digit_val, dp_val and invalid have been updated from a complete frame.

Function
REQ-011 seg_in, dp_in and digit_en SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Stability counter SHALL reset to 0 whenever the synchronized {digit_en, seg_in, dp_in} differs from its previous-cycle value, and SHALL otherwise increment, saturating at STABLE_CYCLES-1.
REQ-013 A capture SHALL occur on the edge where the counter reaches STABLE_CYCLES-1, provided digit_en is one-hot; each dwell SHALL produce at most one capture.
REQ-014 If digit_en is all-zero or has more than one bit set, no capture SHALL occur; this is the blanking or ghosting case.
REQ-015 Decode table, active-high abcdefg:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
REQ-016 On a capture, the selected slot of the shadow registers SHALL store the decoded nibble and dp_in, and SHALL mark the slot as seen.
REQ-017 An unmatched pattern SHALL store nibble 0 and set the slot's shadow invalid bit; a matched pattern SHALL clear that bit.
REQ-018 Recapturing an already-seen slot before the frame completes SHALL overwrite that slot; it SHALL NOT count as progress toward frame completion.
REQ-019 Frame completion SHALL be detected when the seen mask reaches 4'b1111.
- On the edge after the completing capture, the shadow registers SHALL be copied to digit_val, dp_val and invalid.
- frame_valid SHALL be high for exactly that one cycle.
- The seen mask SHALL clear on the same edge.
REQ-020 Outputs SHALL hold their values between frames; frame_valid SHALL never be high for two consecutive cycles.
REQ-021 No FSM beyond the seen mask is required; the capture path SHALL be fully pipelined with no stall.

Reset
REQ-022 Asserting rst_n low SHALL immediately clear to 0:
- synchronizers, counter, seen mask and shadow registers;
- digit_val, dp_val, invalid and frame_valid.
REQ-023 A reset that occurs mid-frame SHALL discard partial captures; after release, a frame SHALL require 4 fresh captures.

Structure
REQ-024 The decode table constants (16 patterns) and the NUM_DIGITS=4 constant SHALL reside in the shared package sevenseg_pkg.
REQ-025 Pattern-to-nibble decoding SHALL be a combinational sub-module seg_to_hex (7-bit pattern in, 4-bit nibble out, match flag out), instantiated once.

Verification
REQ-026 Scan digits 0..3 with patterns for 1, 2, 3, 4, dp on digit 2, dwell 10 cycles each -> one frame_valid pulse; digit_val=16'h4321; dp_val=4'b0100; invalid=0.
REQ-027 Digit 1 dwell of STABLE_CYCLES-1 cycles, other digits normal -> no frame_valid until digit 1 dwells at least STABLE_CYCLES+2 cycles.
REQ-028 digit_en=4'b0011 for 20 cycles, then a normal scan -> the ghost interval produces no capture; the frame completes only after all 4 clean dwells.
REQ-029 Digit 0 pattern 1010101 -> digit_val[3:0]=0 and invalid[0]=1; the next frame with pattern 1000111 gives nibble F and invalid[0]=0.
REQ-030 Assert rst_n low after 2 of 4 captures, then release and scan 4 digits -> exactly one frame_valid pulse, containing only post-reset data.
REQ-031 Hold digit 2 steady for 100 cycles, then scan the rest -> a single capture for digit 2 and exactly one frame_valid pulse.
